// File: rtl/fpadd_disp_pkg.sv
// -----------------------------------------------------------------------------
// fpadd_disp_pkg
// Shared definitions for the FP adder 7-segment display driver:
//   - state_e   : scan controller states (idle, first pass, looping)
//   - SEG_BLANK : all segments off (active-low)
//   - HEX_SEG   : nibble -> {a,b,c,d,e,f,g} active-low glyph table,
//                 lowercase glyphs for 'b' and 'd'
// -----------------------------------------------------------------------------
package fpadd_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_LOOP  = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Bit 6 is segment a, bit 0 is segment g; a 0 lights the segment.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06,   // 0 1 2 3
        7'h4C, 7'h24, 7'h20, 7'h0F,   // 4 5 6 7
        7'h00, 7'h04, 7'h08, 7'h60,   // 8 9 A b
        7'h31, 7'h42, 7'h30, 7'h38    // C d E F
    };

endpackage

// File: rtl/hex_to_7seg.sv
// -----------------------------------------------------------------------------
// hex_to_7seg
// Combinational nibble to 7-segment decoder.
// Ports:
//   nibble in  4  hex digit value
//   seg    out 7  {a,b,c,d,e,f,g}, active-low
// -----------------------------------------------------------------------------
module hex_to_7seg
    import fpadd_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/fpadd_display_driver.sv
// -----------------------------------------------------------------------------
// fpadd_display_driver
// Transmit side of the board 7-segment interface for the FP adder. A 32-bit
// sum is accepted over valid/ready, held, and scanned out one byte per page
// (MSB byte first) across two time-multiplexed hex digits. After the first
// full pass the pages keep cycling and a new word may be loaded.
// Ports:
//   clk, rst (sync, active-high)
//   res_valid/res_data/res_ready : load handshake for the 32-bit sum
//   busy                         : first pass over the current word running
//   an0, a0..g0, fp0             : digit 0 (low nibble), all active-low
//   an1, a1..g1, fp1             : digit 1 (high nibble), all active-low
// Build option: define PAGE_DP_EN to show the binary page index on the
// decimal points (fp1 = page[1], fp0 = page[0]); otherwise dots stay off.
// -----------------------------------------------------------------------------
module fpadd_display_driver
    import fpadd_disp_pkg::*;
#(
    parameter int REFRESH_CYCLES = 50000,
    parameter int PAGE_CYCLES    = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        res_valid,
    input  logic [31:0] res_data,
    output logic        res_ready,
    output logic        busy,
    output logic        an0,
    output logic        a0, b0, c0, d0, e0, f0, g0,
    output logic        fp0,
    output logic        an1,
    output logic        a1, b1, c1, d1, e1, f1, g1,
    output logic        fp1
);

    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int PW = (PAGE_CYCLES > 1) ? $clog2(PAGE_CYCLES) : 1;
    localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_CYCLES - 1);
    localparam logic [PW-1:0] PAGE_LAST = PW'(PAGE_CYCLES - 1);

    state_e          state_q, state_d;
    logic [31:0]     word_q, word_d;
    logic [1:0]      page_q, page_d;
    logic [RW-1:0]   ref_cnt_q, ref_cnt_d;
    logic [PW-1:0]   page_cnt_q, page_cnt_d;
    logic            sel_q, sel_d;
    logic            res_ready_q, res_ready_d;
    logic            busy_q, busy_d;
    logic            an0_q, an0_d, an1_q, an1_d;
    logic            fp0_q, fp0_d, fp1_q, fp1_d;
    logic [6:0]      seg0_q, seg0_d, seg1_q, seg1_d;

    logic            load;
    logic [7:0]      page_byte;
    logic [3:0]      nibble;
    logic [6:0]      seg_lit;

    assign load      = res_valid && res_ready_q;
    assign page_byte = word_q[{page_q, 3'b000} +: 8];
    assign nibble    = sel_q ? page_byte[7:4] : page_byte[3:0];

    hex_to_7seg u_hex (
        .nibble (nibble),
        .seg    (seg_lit)
    );

    // Scan controller: load, refresh/page counters and state transitions.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        page_d     = page_q;
        ref_cnt_d  = ref_cnt_q;
        page_cnt_d = page_cnt_q;
        sel_d      = sel_q;

        if (load) begin
            // A load restarts the scan even if a page wrap lands on this edge.
            state_d    = ST_FIRST;
            word_d     = res_data;
            page_d     = 2'd3;
            ref_cnt_d  = '0;
            page_cnt_d = '0;
            sel_d      = 1'b0;
        end else if (state_q != ST_IDLE) begin
            if (ref_cnt_q == REF_LAST) begin
                ref_cnt_d = '0;
                sel_d     = ~sel_q;
            end else begin
                ref_cnt_d = ref_cnt_q + 1'b1;
            end

            if (page_cnt_q == PAGE_LAST) begin
                page_cnt_d = '0;
                page_d     = page_q - 2'd1;   // 0 wraps to 3
                if (state_q == ST_FIRST && page_q == 2'd0) begin
                    state_d = ST_LOOP;
                end
            end else begin
                page_cnt_d = page_cnt_q + 1'b1;
            end
        end

        // Handshake flags track the next state so res_ready never admits a
        // second load during the first pass.
        res_ready_d = (state_d != ST_FIRST);
        busy_d      = (state_d == ST_FIRST);
    end

    // Pin drivers: derived from the current state, so pins lag it by 1 clk.
    always_comb begin
        an0_d  = 1'b1;
        an1_d  = 1'b1;
        seg0_d = SEG_BLANK;
        seg1_d = SEG_BLANK;
        fp0_d  = 1'b1;
        fp1_d  = 1'b1;

        if (state_q != ST_IDLE) begin
            if (sel_q) begin
                an1_d  = 1'b0;
                seg1_d = seg_lit;
`ifdef PAGE_DP_EN
                fp1_d  = ~page_q[1];
`endif
            end else begin
                an0_d  = 1'b0;
                seg0_d = seg_lit;
`ifdef PAGE_DP_EN
                fp0_d  = ~page_q[0];
`endif
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            word_q      <= '0;
            page_q      <= 2'd3;
            ref_cnt_q   <= '0;
            page_cnt_q  <= '0;
            sel_q       <= 1'b0;
            res_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            an0_q       <= 1'b1;
            an1_q       <= 1'b1;
            seg0_q      <= SEG_BLANK;
            seg1_q      <= SEG_BLANK;
            fp0_q       <= 1'b1;
            fp1_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            page_q      <= page_d;
            ref_cnt_q   <= ref_cnt_d;
            page_cnt_q  <= page_cnt_d;
            sel_q       <= sel_d;
            res_ready_q <= res_ready_d;
            busy_q      <= busy_d;
            an0_q       <= an0_d;
            an1_q       <= an1_d;
            seg0_q      <= seg0_d;
            seg1_q      <= seg1_d;
            fp0_q       <= fp0_d;
            fp1_q       <= fp1_d;
        end
    end

    assign res_ready                  = res_ready_q;
    assign busy                       = busy_q;
    assign an0                        = an0_q;
    assign an1                        = an1_q;
    assign {a0, b0, c0, d0, e0, f0, g0} = seg0_q;
    assign {a1, b1, c1, d1, e1, f1, g1} = seg1_q;
    assign fp0                        = fp0_q;
    assign fp1                        = fp1_q;

endmodule

// File: tb/tb_fpadd_display_driver.sv
// -----------------------------------------------------------------------------
// tb_fpadd_display_driver
// Self-checking bench for fpadd_display_driver with REFRESH_CYCLES=4 and
// PAGE_CYCLES=16. The reference model tracks only "is a word shown, which
// word, and how many clocks since it was loaded"; digit, page and glyph follow
// from that elapsed time. Define PAGE_DP_EN for both DUT and bench to cover
// the page-index decimal points.
// -----------------------------------------------------------------------------
module tb_fpadd_display_driver;

    localparam int REF = 4;
    localparam int PG  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_ready, busy;
    logic        an0, a0, b0, c0, d0, e0, f0, g0, fp0;
    logic        an1, a1, b1, c1, d1, e1, f1, g1, fp1;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    bit          m_active = 1'b0;
    logic [31:0] m_word   = '0;
    int          m_el     = 0;

    typedef struct {
        logic [31:0] word;
        logic [6:0]  hi_seg;   // digit 1 on page 3, abcdefg active-low
        logic [6:0]  lo_seg;   // digit 0 on page 3
    } vec_t;

    vec_t vecs [8];

    fpadd_display_driver #(
        .REFRESH_CYCLES (REF),
        .PAGE_CYCLES    (PG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .busy      (busy),
        .an0       (an0),
        .a0 (a0), .b0 (b0), .c0 (c0), .d0 (d0), .e0 (e0), .f0 (f0), .g0 (g0),
        .fp0       (fp0),
        .an1       (an1),
        .a1 (a1), .b1 (b1), .c1 (c1), .d1 (d1), .e1 (e1), .f1 (f1), .g1 (g1),
        .fp1       (fp1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %05h expected %05h at %0t", name, act, exp, $time);
        end
    endtask

    // Glyph as the list of lit segments, turned into active-low {a..g}.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        string lit;
        logic [6:0] s;
        case (n)
            4'h0: lit = "abcdef";  4'h1: lit = "bc";
            4'h2: lit = "abdeg";   4'h3: lit = "abcdg";
            4'h4: lit = "bcfg";    4'h5: lit = "acdfg";
            4'h6: lit = "acdefg";  4'h7: lit = "abc";
            4'h8: lit = "abcdefg"; 4'h9: lit = "abcdfg";
            4'hA: lit = "abcefg";  4'hB: lit = "cdefg";
            4'hC: lit = "adef";    4'hD: lit = "bcdeg";
            4'hE: lit = "adefg";   default: lit = "aefg";
        endcase
        s = 7'h7F;
        for (int i = 0; i < lit.len(); i++) begin
            s[6 - (int'(lit[i]) - 97)] = 1'b0;
        end
        return s;
    endfunction

    // Expected {an1,seg1,fp1,an0,seg0,fp0} for a given model state.
    function automatic logic [17:0] disp(input bit act, input logic [31:0] w, input int el);
        int         page;
        bit         sel;
        logic [7:0] byt;
        logic [3:0] nib;
        logic [8:0] dig1, dig0;
        bit         dp1, dp0;
        if (!act) return 18'h3FFFF;
        sel  = ((el / REF) % 2) == 1;
        page = 3 - ((el / PG) % 4);
        byt  = 8'(w >> (8 * page));
        nib  = sel ? byt[7:4] : byt[3:0];
        dp1  = 1'b1;
        dp0  = 1'b1;
`ifdef PAGE_DP_EN
        dp1  = !(page >= 2);
        dp0  = !(page % 2 == 1);
`endif
        dig1 = {1'b1, 7'h7F, 1'b1};
        dig0 = {1'b1, 7'h7F, 1'b1};
        if (sel) dig1 = {1'b0, glyph(nib), dp1};
        else     dig0 = {1'b0, glyph(nib), dp0};
        return {dig1, dig0};
    endfunction

    function automatic logic [19:0] pins();
        return {an1, a1, b1, c1, d1, e1, f1, g1, fp1,
                an0, a0, b0, c0, d0, e0, f0, g0, fp0, res_ready, busy};
    endfunction

    // Drive inputs for one edge, advance the model, compare everything.
    task automatic step(input bit r, input bit v, input logic [31:0] d, input string name);
        logic [17:0] exp_disp;
        bit ready_pre, load, exp_busy, exp_ready;
        rst       = r;
        res_valid = v;
        res_data  = d;
        ready_pre = !m_active || (m_el >= 4 * PG);
        load      = v && ready_pre && !r;
        exp_disp  = disp(m_active, m_word, m_el);
        @(posedge clk);
        if (r) begin
            m_active = 1'b0;
            m_word   = '0;
            m_el     = 0;
            exp_disp = 18'h3FFFF;
        end else if (load) begin
            m_active = 1'b1;
            m_word   = d;
            m_el     = 0;
        end else if (m_active) begin
            m_el++;
        end
        exp_busy  = m_active && (m_el < 4 * PG);
        exp_ready = !exp_busy;
        #1;
        check(name, pins(), {exp_disp, exp_ready, exp_busy});
    endtask

    initial begin
        rst       = 1'b1;
        res_valid = 1'b0;
        res_data  = '0;

        vecs[0] = '{32'h3F800000, 7'b0000110, 7'b0111000};  // 3 F
        vecs[1] = '{32'hC0000000, 7'b0110001, 7'b0000001};  // C 0
        vecs[2] = '{32'hAB000000, 7'b0001000, 7'b1100000};  // A b
        vecs[3] = '{32'h12000000, 7'b1001111, 7'b0010010};  // 1 2
        vecs[4] = '{32'h45000000, 7'b1001100, 7'b0100100};  // 4 5
        vecs[5] = '{32'h67000000, 7'b0100000, 7'b0001111};  // 6 7
        vecs[6] = '{32'h89000000, 7'b0000000, 7'b0000100};  // 8 9
        vecs[7] = '{32'hDE000000, 7'b1000010, 7'b0110000};  // d E

        // Reset for 2 clks, then 10 idle clks stay blank and ready.
        step(1, 0, 0, "reset");
        step(1, 0, 0, "reset");
        for (int i = 0; i < 10; i++) step(0, 0, 0, "idle");

        // Glyph table: page 3 of each word, digit 0 then digit 1.
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, "tbl_rst");
            step(0, 1, vecs[i].word, "tbl_load");
            step(0, 0, 0, "tbl_d0");
            check("tbl_lo_glyph", {13'h0, an0, a0, b0, c0, d0, e0, f0, g0},
                  {13'h0, 1'b0, vecs[i].lo_seg});
            for (int k = 0; k < REF; k++) step(0, 0, 0, "tbl_run");
            check("tbl_hi_glyph", {13'h0, an1, a1, b1, c1, d1, e1, f1, g1},
                  {13'h0, 1'b0, vecs[i].hi_seg});
        end

        // Full first pass, ignored load during FIRST, then accepted in LOOP.
        step(1, 0, 0, "seq_rst");
        step(0, 1, 32'h3F800000, "seq_load");
        for (int i = 0; i < 20; i++) step(0, 0, 0, "seq_first");
        step(0, 1, 32'hC0000000, "seq_ignored_load");
        for (int i = 0; i < 50; i++) step(0, 0, 0, "seq_first");
        check("seq_loop_ready", {19'h0, res_ready}, 20'h1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, "seq_loop");
        step(0, 1, 32'hC0000000, "seq_loop_load");
        step(0, 0, 0, "seq_c0_page3");
        check("seq_busy_after_reload", {19'h0, busy}, 20'h1);

        // Load landing exactly on a LOOP page wrap.
        for (int i = 0; i < 4 * PG + PG - 2; i++) step(0, 0, 0, "wrap_run");
        step(0, 1, 32'h89ABCDEF, "wrap_load");
        for (int i = 0; i < 8; i++) step(0, 0, 0, "wrap_after");

        // Reset on page 1 of FIRST.
        step(0, 1, 32'h0F1E2D3C, "mid_load");
        for (int i = 0; i < 2 * PG + 3; i++) step(0, 0, 0, "mid_run");
        step(1, 0, 0, "mid_rst");
        check("mid_rst_blank", {18'h0, an0, an1}, 20'h3);
        for (int i = 0; i < 3; i++) step(0, 0, 0, "mid_idle");

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 19) == 0),
                 $urandom, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
